// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register: resolves operands through EX/MEM and MEM/WB bypasses,
// stalls on load-use hazards and hands operands to the ALU over valid/ready.
module idex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [DATA_WIDTH-1:0]     rs1_rdata_i,
  input  logic [DATA_WIDTH-1:0]     rs2_rdata_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic                      use_imm_i,
  input  logic [3:0]                alu_op_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_we_i,
  input  logic                      fwd_a_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_a_addr_i,
  input  logic [DATA_WIDTH-1:0]     fwd_a_data_i,
  input  logic                      fwd_a_pending_i,
  input  logic                      fwd_b_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_b_addr_i,
  input  logic [DATA_WIDTH-1:0]     fwd_b_data_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     op_a_o,
  output logic [DATA_WIDTH-1:0]     op_b_o,
  output logic [3:0]                alu_op_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]     op_b_q, op_b_d;
  logic [3:0]                alu_op_q, alu_op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      rd_we_q, rd_we_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                      use_imm_q, use_imm_d;
  logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;

  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic                  hazard, capture;

  // Port A outranks port B; x0 is hardwired to zero and never bypassed.
  always_comb begin
    if (rs1_addr_i == '0)                                rs1_val = '0;
    else if (fwd_a_we_i && fwd_a_addr_i == rs1_addr_i)   rs1_val = fwd_a_data_i;
    else if (fwd_b_we_i && fwd_b_addr_i == rs1_addr_i)   rs1_val = fwd_b_data_i;
    else                                                 rs1_val = rs1_rdata_i;

    if (rs2_addr_i == '0)                                rs2_val = '0;
    else if (fwd_a_we_i && fwd_a_addr_i == rs2_addr_i)   rs2_val = fwd_a_data_i;
    else if (fwd_b_we_i && fwd_b_addr_i == rs2_addr_i)   rs2_val = fwd_b_data_i;
    else                                                 rs2_val = rs2_rdata_i;
  end

  assign hazard = in_valid_i && fwd_a_we_i && fwd_a_pending_i && (fwd_a_addr_i != '0) &&
                  ((fwd_a_addr_i == rs1_addr_i) || (!use_imm_i && fwd_a_addr_i == rs2_addr_i));
  assign in_ready_o = (!valid_q || out_ready_i) && !hazard && !flush_i;
  assign capture    = in_valid_i && in_ready_o;

  always_comb begin
    valid_d   = valid_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    alu_op_d  = alu_op_q;
    rd_addr_d = rd_addr_q;
    rd_we_d   = rd_we_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;
    if (flush_i) begin
      valid_d = 1'b0;
      rd_we_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      op_a_d    = rs1_val;
      op_b_d    = use_imm_i ? imm_i : rs2_val;
      alu_op_d  = alu_op_i;
      rd_addr_d = rd_addr_i;
      rd_we_d   = rd_we_i;
      pc_d      = pc_i;
      rs1_d     = rs1_addr_i;
      rs2_d     = rs2_addr_i;
      use_imm_d = use_imm_i;
    end else if (valid_q && !out_ready_i) begin
      // A held entry keeps watching writeback so it never leaves with a stale operand.
      if (fwd_b_we_i && rs1_q != '0 && fwd_b_addr_i == rs1_q)
        op_a_d = fwd_b_data_i;
      if (fwd_b_we_i && !use_imm_q && rs2_q != '0 && fwd_b_addr_i == rs2_q)
        op_b_d = fwd_b_data_i;
    end else begin
      valid_d = 1'b0;
      rd_we_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush_i && stall_cnt_q != {CNT_WIDTH{1'b1}})
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      alu_op_q    <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_op_q    <= alu_op_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use_imm_q   <= use_imm_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign alu_op_o    = alu_op_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_we_o     = rd_we_q;
  assign pc_o        = pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: directed scenarios plus random traffic, all
// checked against a transaction-level reference model of the stage.
module tb_idex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid_i, in_ready_o, use_imm_i, rd_we_i;
  logic [DW-1:0] pc_i, rs1_rdata_i, rs2_rdata_i, imm_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]    alu_op_i;
  logic          fwd_a_we_i, fwd_a_pending_i, fwd_b_we_i, flush_i, out_ready_i;
  logic [AW-1:0] fwd_a_addr_i, fwd_b_addr_i;
  logic [DW-1:0] fwd_a_data_i, fwd_b_data_i;
  logic          out_valid_o, rd_we_o;
  logic [DW-1:0] op_a_o, op_b_o, pc_o;
  logic [3:0]    alu_op_o;
  logic [AW-1:0] rd_addr_o;
  logic [CW-1:0] stall_cnt_o;

  idex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i), .imm_i(imm_i),
    .use_imm_i(use_imm_i), .alu_op_i(alu_op_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .fwd_a_we_i(fwd_a_we_i), .fwd_a_addr_i(fwd_a_addr_i), .fwd_a_data_i(fwd_a_data_i),
    .fwd_a_pending_i(fwd_a_pending_i), .fwd_b_we_i(fwd_b_we_i), .fwd_b_addr_i(fwd_b_addr_i),
    .fwd_b_data_i(fwd_b_data_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .op_a_o(op_a_o), .op_b_o(op_b_o), .alu_op_o(alu_op_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .pc_o(pc_o), .stall_cnt_o(stall_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the one instruction slot the ALU currently sees.
  typedef struct {
    bit            valid;
    logic [DW-1:0] op_a, op_b, pc;
    logic [3:0]    alu;
    logic [AW-1:0] rd, rs1, rs2;
    bit            rd_we, uimm;
  } slot_t;

  slot_t m;
  int    m_cnt;

  function automatic logic [DW-1:0] src_value(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    if (idx == 0) return '0;
    if (fwd_a_we_i && fwd_a_addr_i == idx) return fwd_a_data_i;
    if (fwd_b_we_i && fwd_b_addr_i == idx) return fwd_b_data_i;
    return rf;
  endfunction

  task automatic idle();
    rst = 0; in_valid_i = 0; pc_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    rs1_rdata_i = 0; rs2_rdata_i = 0; imm_i = 0; use_imm_i = 0; alu_op_i = 0;
    rd_addr_i = 0; rd_we_i = 0; fwd_a_we_i = 0; fwd_a_addr_i = 0; fwd_a_data_i = 0;
    fwd_a_pending_i = 0; fwd_b_we_i = 0; fwd_b_addr_i = 0; fwd_b_data_i = 0;
    flush_i = 0; out_ready_i = 1;
  endtask

  task automatic instr(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [DW-1:0] imm, input logic ui, input logic [3:0] op,
                       input logic [DW-1:0] pc);
    in_valid_i = 1; rs1_addr_i = r1; rs2_addr_i = r2; rs1_rdata_i = d1; rs2_rdata_i = d2;
    imm_i = imm; use_imm_i = ui; alu_op_i = op; pc_i = pc;
    rd_addr_i = AW'(pc[6:2]); rd_we_i = 1;
  endtask

  // One clock: check in_ready, advance the model, check the registered outputs.
  task automatic cycle();
    bit    hz, rdy;
    slot_t n;
    #1;
    hz  = in_valid_i && fwd_a_we_i && fwd_a_pending_i && fwd_a_addr_i != 0 &&
          (fwd_a_addr_i == rs1_addr_i || (!use_imm_i && fwd_a_addr_i == rs2_addr_i));
    rdy = (!m.valid || out_ready_i) && !hz && !flush_i;
    chk("in_ready", {63'd0, in_ready_o}, {63'd0, rdy});
    n = m;
    if (rst) begin
      n = '{valid: 0, op_a: 0, op_b: 0, pc: 0, alu: 0, rd: 0, rs1: 0, rs2: 0, rd_we: 0, uimm: 0};
      m_cnt = 0;
    end else begin
      if (flush_i) begin
        n.valid = 0; n.rd_we = 0;
      end else if (in_valid_i && rdy) begin
        n.valid = 1; n.op_a = src_value(rs1_addr_i, rs1_rdata_i);
        n.op_b = use_imm_i ? imm_i : src_value(rs2_addr_i, rs2_rdata_i);
        n.alu = alu_op_i; n.rd = rd_addr_i; n.rd_we = rd_we_i; n.pc = pc_i;
        n.rs1 = rs1_addr_i; n.rs2 = rs2_addr_i; n.uimm = use_imm_i;
        $display("[TB] accept pc=%08h op_a=%08h op_b=%08h alu=%0h", pc_i, n.op_a, n.op_b, alu_op_i);
      end else if (m.valid && !out_ready_i) begin
        if (fwd_b_we_i && m.rs1 != 0 && fwd_b_addr_i == m.rs1) n.op_a = fwd_b_data_i;
        if (fwd_b_we_i && !m.uimm && m.rs2 != 0 && fwd_b_addr_i == m.rs2) n.op_b = fwd_b_data_i;
      end else begin
        n.valid = 0; n.rd_we = 0;
      end
      if (hz && !flush_i && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(posedge clk);
    m = n;
    #1;
    chk("out_valid", {63'd0, out_valid_o}, {63'd0, m.valid});
    chk("rd_we", {63'd0, rd_we_o}, {63'd0, m.rd_we});
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    if (m.valid || rst) begin
      chk("op_a", 64'(op_a_o), 64'(m.op_a));
      chk("op_b", 64'(op_b_o), 64'(m.op_b));
      chk("alu_op", 64'(alu_op_o), 64'(m.alu));
      chk("rd_addr", 64'(rd_addr_o), 64'(m.rd));
      chk("pc", 64'(pc_o), 64'(m.pc));
    end
    @(negedge clk);
  endtask

  initial begin
    m = '{valid: 0, op_a: 0, op_b: 0, pc: 0, alu: 0, rd: 0, rs1: 0, rs2: 0, rd_we: 0, uimm: 0};
    m_cnt = 0;
    idle();
    @(negedge clk);

    // Reset
    rst = 1; cycle(); rst = 0;
    chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
    #1 chk("rst_ready", {63'd0, in_ready_o}, 64'd1);

    // Basic capture
    instr(3, 4, 10, 20, 0, 0, 4'b0000, 32'h40); cycle();
    chk("basic_a", 64'(op_a_o), 64'd10);
    chk("basic_b", 64'(op_b_o), 64'd20);
    chk("basic_valid", {63'd0, out_valid_o}, 64'd1);

    // Forwarding priority and x0
    instr(5, 0, 1, 2, 0, 0, 4'b0001, 32'h44);
    fwd_a_we_i = 1; fwd_a_addr_i = 5; fwd_a_data_i = 32'hAAAA;
    fwd_b_we_i = 1; fwd_b_addr_i = 5; fwd_b_data_i = 32'hBBBB;
    cycle(); chk("fwd_a_prio", 64'(op_a_o), 64'hAAAA);
    fwd_a_we_i = 0; cycle(); chk("fwd_b", 64'(op_a_o), 64'hBBBB);
    rs1_addr_i = 0; fwd_a_we_i = 1; fwd_a_addr_i = 0; fwd_b_addr_i = 0;
    cycle(); chk("fwd_x0", 64'(op_a_o), 64'd0);

    // Load-use stall on rs2, then the immediate form that must not stall
    idle(); rst = 1; cycle(); rst = 0;
    instr(1, 7, 11, 22, 32'h123, 0, 4'b0010, 32'h80);
    fwd_a_we_i = 1; fwd_a_addr_i = 7; fwd_a_data_i = 32'h77; fwd_a_pending_i = 1;
    cycle(); cycle();
    chk("lu_cnt", 64'(stall_cnt_o), 64'd2);
    fwd_a_pending_i = 0; cycle();
    chk("lu_b", 64'(op_b_o), 64'h77);
    fwd_a_pending_i = 1; use_imm_i = 1; cycle();
    chk("imm_b", 64'(op_b_o), 64'h123);
    chk("imm_cnt", 64'(stall_cnt_o), 64'd2);

    // Hold with port-B snoop
    idle(); instr(9, 0, 1, 0, 0, 0, 4'b0011, 32'hC0); cycle();
    idle(); out_ready_i = 0; fwd_b_we_i = 1; fwd_b_addr_i = 9; fwd_b_data_i = 32'h55;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("snoop_a", 64'(op_a_o), 64'h55);
    end
    fwd_b_we_i = 0; out_ready_i = 1; cycle();
    chk("snoop_drain", {63'd0, out_valid_o}, 64'd0);

    // Flush while held with a new instruction waiting
    idle(); instr(2, 3, 5, 6, 0, 0, 4'b0100, 32'h100); cycle();
    out_ready_i = 0; instr(4, 5, 7, 8, 0, 0, 4'b0101, 32'h200); flush_i = 1; cycle();
    chk("flush_valid", {63'd0, out_valid_o}, 64'd0);
    chk("flush_rdwe", {63'd0, rd_we_o}, 64'd0);
    idle(); cycle();
    chk("flush_drop", {63'd0, out_valid_o}, 64'd0);

    // Back-to-back stream, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      instr(AW'(i + 1), AW'(i + 2), DW'(i * 3), DW'(i * 5), 0, 0, 4'(i), DW'(i * 4));
      cycle();
      chk("b2b_valid", {63'd0, out_valid_o}, 64'd1);
      chk("b2b_pc", 64'(pc_o), 64'(i * 4));
    end
    rst = 1; cycle(); rst = 0;
    chk("mid_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("mid_rst_cnt", 64'(stall_cnt_o), 64'd0);

    // Counter saturation
    idle(); instr(6, 0, 0, 0, 0, 1, 0, 32'h300);
    fwd_a_we_i = 1; fwd_a_addr_i = 6; fwd_a_pending_i = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("cnt_sat", 64'(stall_cnt_o), 64'((1 << CW) - 1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      in_valid_i      = ($urandom_range(0, 3) != 0);
      pc_i            = $urandom;
      rs1_addr_i      = AW'($urandom_range(0, 7));
      rs2_addr_i      = AW'($urandom_range(0, 7));
      rs1_rdata_i     = $urandom;
      rs2_rdata_i     = $urandom;
      imm_i           = $urandom;
      use_imm_i       = $urandom_range(0, 1) == 1;
      alu_op_i        = 4'($urandom);
      rd_addr_i       = AW'($urandom);
      rd_we_i         = $urandom_range(0, 1) == 1;
      fwd_a_we_i      = $urandom_range(0, 1) == 1;
      fwd_a_addr_i    = AW'($urandom_range(0, 7));
      fwd_a_data_i    = $urandom;
      fwd_a_pending_i = ($urandom_range(0, 3) == 0);
      fwd_b_we_i      = $urandom_range(0, 1) == 1;
      fwd_b_addr_i    = AW'($urandom_range(0, 7));
      fwd_b_data_i    = $urandom;
      flush_i         = ($urandom_range(0, 19) == 0);
      out_ready_i     = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
